// File: rtl/rr_grant_ctrl.sv
// Four-requester round-robin grant controller with a non-preemptive hold and a one-cycle idle gap between grants.
// Optional grant-hold timeout is enabled by defining RR_GRANT_TIMEOUT_EN.
module rr_grant_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned CNT_W   = 8;

  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
    $error("rr_grant_ctrl: TIMEOUT_CYC must be in 2..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [3:0]        gnt_nxt;
  logic [ID_W-1:0]   gnt_id_nxt;
  logic              busy_nxt;
  logic              timeout_err_nxt;

  logic [PTR_W-1:0]  win;
  logic              win_vld;
  logic [PTR_W-1:0]  idx;
  logic [PTR_W-1:0]  cur;
  logic              abandon;
  logic              tc;

`ifdef RR_GRANT_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  assign tc = (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tc = 1'b0;
`endif

  assign cur     = gnt_id[PTR_W-1:0];
  assign abandon = ~req[cur];

  // Rotating priority search; scanning from the far end lets the nearest set bit win.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    idx     = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + PTR_W'(k);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    gnt_nxt         = gnt;
    gnt_id_nxt      = gnt_id;
    busy_nxt        = busy;
    timeout_err_nxt = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
    cnt_nxt         = cnt;
`endif
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt  = GRANT;
          gnt_nxt    = 4'b0001 << win;
          gnt_id_nxt = {1'b0, win};
          busy_nxt   = 1'b1;
`ifdef RR_GRANT_TIMEOUT_EN
          cnt_nxt    = '0;
`endif
        end
      end
      GRANT: begin
        if (done || abandon || tc) begin
          // done/abandon outrank the terminal count, so only a bare timeout flags an error
          state_nxt       = IDLE;
          ptr_nxt         = cur + PTR_W'(1);
          gnt_nxt         = '0;
          gnt_id_nxt      = ID_W'(NUM_REQ);
          busy_nxt        = 1'b0;
          timeout_err_nxt = tc && !done && !abandon;
        end else begin
`ifdef RR_GRANT_TIMEOUT_EN
          cnt_nxt = cnt + CNT_W'(1);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt         <= '0;
      gnt_id      <= ID_W'(NUM_REQ);
      busy        <= 1'b0;
      timeout_err <= 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      gnt         <= gnt_nxt;
      gnt_id      <= gnt_id_nxt;
      busy        <= busy_nxt;
      timeout_err <= timeout_err_nxt;
`ifdef RR_GRANT_TIMEOUT_EN
      cnt         <= cnt_nxt;
`endif
    end
  end

endmodule

// File: doc/rr_grant_ctrl.md
RR_GRANT_CTRL -- requirements
Module: rr_grant_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 16, max cycles a grant may be held without done (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req  input  4  per-requester request level; bit i = requester i.
REQ-005 done  input  1  single-cycle pulse from the shared resource: current transaction complete.
REQ-006 gnt  output  4  registered one-hot grant; all-zero when no grant.
REQ-007 gnt_id  output  3  registered index of granted requester 0..3; 4 when no grant.
REQ-008 busy  output  1  high while in state GRANT.
REQ-009 timeout_err  output  1  single-cycle pulse on forced release.

Function
REQ-010 The block SHALL implement two states: IDLE and GRANT.
REQ-011 The block SHALL hold a 2-bit priority pointer ptr naming the highest-priority requester.
REQ-012 In IDLE with req != 0, the winner SHALL be the first set bit searching ptr, ptr+1, ... modulo 4.
REQ-013 The block SHALL enter GRANT on the next edge; gnt/gnt_id/busy reflect the winner from that edge (latency 1 cycle from sampled req).
REQ-014 In IDLE with req == 0: state, ptr, and the outputs SHALL be unchanged (gnt=0, gnt_id=4, busy=0).
REQ-015 In GRANT, gnt/gnt_id SHALL stay constant regardless of other req bits (no preemption).
REQ-016 In GRANT, done=1 SHALL return to IDLE on the next edge, with ptr <= winner+1 mod 4.
REQ-017 In GRANT, the granted requester's req bit at 0 (abandon) SHALL return to IDLE on the next edge, with ptr <= winner+1 mod 4.
REQ-018 Done and abandon in the same cycle SHALL be treated as done; the same state update applies.
REQ-019 After any release, the block SHALL spend at least one cycle in IDLE with gnt=0 before issuing a new grant (no back-to-back grants).
REQ-020 done while in IDLE SHALL be ignored.
REQ-021 Pointer wrap: winner 3 SHALL set ptr to 0.
REQ-022 Simultaneous requests on all four bits SHALL yield grants rotating in order ptr, ptr+1, ... across successive transactions.

Reset
REQ-023 While rst=1, asynchronously: state=IDLE, ptr=0, gnt=0, gnt_id=4, busy=0, timeout_err=0, timeout counter=0.
REQ-024 Reset asserted mid-GRANT SHALL drop the grant immediately and discard the transaction; the first grant after release uses ptr=0.

Configuration
REQ-025 Macro RR_GRANT_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-026 With the macro defined, if the counter reaches TIMEOUT_CYC-1 with no done and no abandon, the block SHALL force IDLE on the next edge, pulse timeout_err for that one cycle, and set ptr <= winner+1.
REQ-027 With the macro defined, done or abandon in the terminal-count cycle SHALL take precedence; no timeout_err.
REQ-028 Macro undefined: no counter is present, timeout_err SHALL be constant 0, and a grant is held until done or abandon.

Verification
REQ-029 Reset, then req=4'b0101 at edge 1 -> gnt=4'b0001, gnt_id=0 after edge 2; done pulse -> gnt=0 next cycle; then gnt=4'b0100, gnt_id=2.
REQ-030 req=4'b1111 held, done pulsed 3 cycles after each grant -> gnt_id sequence 0,1,2,3,0 with a gnt=0 cycle between grants.
REQ-031 Granted to 1, req[3] rises mid-grant -> gnt stays 4'b0010 until done; next gnt_id=3.
REQ-032 Granted to 2, req[2] drops with done=0 -> IDLE next cycle, ptr=3; simultaneous done plus drop -> single release, no error.
REQ-033 With RR_GRANT_TIMEOUT_EN and TIMEOUT_CYC=16, grant to 0 with no done -> release after 16 GRANT cycles, timeout_err high 1 cycle, next grant goes to requester 1 if it is requesting.
REQ-034 rst pulsed during GRANT to 3 -> gnt=0 and gnt_id=4 without waiting for clk; after release with req=4'b1001 -> gnt_id=0.
